ex_stage: RTL and testbench
===========================

# ex_stage

Execute stage of the RV32I RISC-V core, between decode/register-read and memory access. It selects the ALU operands, decodes the ALU operation from `ALUOp` and instruction fields, and evaluates branch conditions. It computes the branch/jump target and registers all results into the EX/MEM boundary on the rising clock edge.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk` input 1 — single clock; all outputs update on rising edge.
- `rst_n` input 1 — asynchronous, active-low reset.
- `dataA` input 32 — rs1 value.
- `dataB` input 32 — rs2 value.
- `imm_ext` input 32 — sign-extended immediate from decode.
- `PC` input 32 — address of the instruction in EX.
- `instruction` input 32 — raw instruction word; uses opcode [6:0], funct3 [14:12] and bit 30 (funct7[5]).
- `ALUOp` input 2 — 00 add, 01 branch compare, 10 funct-decoded, 11 pass operand B.
- `ALUSrc` input 1 — 0: operand B = `dataB`; 1: operand B = `imm_ext`.
- `Branch` input 1 — instruction is a conditional branch.
- `alu_result` output 32 — registered ALU result.
- `mem_write_data` output 32 — registered store data (`dataB`).
- `branch_taken` output 1 — registered branch decision.
- `pc_target` output 32 — registered branch/jump target.

## Operation
- Operand A = `dataA`.
- Operand B = `ALUSrc` ? `imm_ext` : `dataB`.
- ALUOp 00 (load, store, JAL, JALR address): A + B.
- ALUOp 01 (branch): A − B.
- ALUOp 11 (LUI): result = B.
- ALUOp 10: decode funct3:
  - 000: ADD, or SUB when opcode = 0110011 and bit30 = 1. I-type (0010011) is always ADD.
  - 001: SLL; 010: SLT (signed); 011: SLTU; 100: XOR.
  - 101: SRL when bit30 = 0, SRA when bit30 = 1; applies to both R- and I-type.
  - 110: OR; 111: AND.
- Shift amount = B[4:0]. SLT/SLTU produce 0x00000001 or 0x00000000.
- All arithmetic is modulo 2^32; overflow is ignored and there is no carry/overflow output.
- Branch condition from funct3:
  - 000 BEQ A==B; 001 BNE A!=B.
  - 100 BLT signed <; 101 BGE signed >=.
  - 110 BLTU unsigned <; 111 BGEU unsigned >=.
  - 010 and 011 give condition false.
- Comparison always uses `dataA` vs `dataB`, independent of `ALUSrc`.
- `branch_taken` = `Branch` & condition. When `Branch` = 0 it is 0 regardless of opcode, including JAL.
- `pc_target`:
  - opcode 1100111 (JALR): (dataA + imm_ext) & ~1.
  - Otherwise: PC + imm_ext, for branches and JAL. It is computed every cycle even when not used.
- `mem_write_data` = `dataB`, unmodified. It is independent of `ALUSrc`.
- Unknown opcodes cause no error; the datapath computes per `ALUOp`.

## Timing
- All results are computed combinationally from the current inputs and captured into output registers on the rising edge of `clk`.
- Latency is 1 cycle: inputs stable before edge N appear at the outputs after edge N.
- Throughput is one instruction per cycle. There is no stall, flush or handshake; inputs are sampled every edge.
- When `rst_n` = 0, all four outputs go to 0 immediately, independent of `clk`. They are held at 0 while reset is asserted.
- On the first rising edge after `rst_n` deasserts, outputs reflect the inputs present at that edge.
- Reset asserted mid-operation discards the in-flight result; nothing is replayed.

## Test plan
- Reset: drive `rst_n` = 0 with nonzero inputs -> all outputs 0 without a clock edge; after release and one edge, outputs track the inputs.
- ADD: instruction 0x003100B3, A = 4, dataB = 5, ALUOp = 10, ALUSrc = 0, Branch = 0 -> after one edge: `alu_result` 0x00000009, `mem_write_data` 0x00000005, `branch_taken` 0.
- ADDI and SUB/SRA:
  - 0x00A10093, A = 4, imm = 10, ALUSrc = 1 -> `alu_result` 0x0000000E.
  - 0x403100B3 (SUB), A = 4, B = 5 -> 0xFFFFFFFF.
  - SRA of 0x80000000 by 4 -> 0xF8000000.
- BEQ taken: 0x00208263, A = B = 10, imm = 0x64, PC = 0x00400000, ALUOp = 01, Branch = 1 -> `branch_taken` 1, `pc_target` 0x00400064. With B = 11 -> `branch_taken` 0.
- BLT/BLTU: A = 0xFFFFFFFF, B = 1 -> BLT taken (−1 < 1); BLTU not taken.
- LW and JAL/JALR:
  - 0x00812083, A = 0x10000004, imm = 8, ALUOp = 00, ALUSrc = 1 -> `alu_result` 0x1000000C.
  - JAL 0x800000EF, imm = 0x800, PC = 0x00400000 -> `pc_target` 0x00400800, `branch_taken` 0.
  - JALR, A = 0x1001, imm = 0 -> `pc_target` 0x00001000.

Source files
------------

// File: rtl/ex_stage.sv
// ex_stage: RV32I execute stage. Selects ALU operands, decodes the ALU
// operation, evaluates the branch condition, computes the branch/jump
// target, and registers all results into the EX/MEM boundary.
module ex_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] dataA,
  input  logic [31:0] dataB,
  input  logic [31:0] imm_ext,
  input  logic [31:0] PC,
  input  logic [31:0] instruction,
  input  logic [1:0]  ALUOp,
  input  logic        ALUSrc,
  input  logic        Branch,
  output logic [31:0] alu_result,
  output logic [31:0] mem_write_data,
  output logic        branch_taken,
  output logic [31:0] pc_target
);

  localparam logic [6:0] OPC_RTYPE = 7'b0110011;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;

  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_BR   = 2'b01;
  localparam logic [1:0] ALU_FUNC = 2'b10;
  localparam logic [1:0] ALU_PASS = 2'b11;

  // instruction field extraction
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       bit30;
  assign opcode = instruction[6:0];
  assign funct3 = instruction[14:12];
  assign bit30  = instruction[30];

  // remaining instruction bits are decoded upstream, not here
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instruction[31], instruction[29:15], instruction[11:7]};

  // operand selection; the comparator always uses the raw register values
  logic [31:0] op_a, op_b;
  logic [4:0]  shamt;
  assign op_a  = dataA;
  assign op_b  = ALUSrc ? imm_ext : dataB;
  assign shamt = op_b[4:0];

  logic [31:0] sum_ab, diff_ab;
  assign sum_ab  = op_a + op_b;
  assign diff_ab = op_a - op_b;

  logic lt_s_ab, lt_u_ab;
  assign lt_s_ab = $signed(op_a) < $signed(op_b);
  assign lt_u_ab = op_a < op_b;

  // ALU result select
  logic [31:0] alu_d;
  always_comb begin
    alu_d = sum_ab;
    unique case (ALUOp)
      ALU_ADD:  alu_d = sum_ab;
      ALU_BR:   alu_d = diff_ab;
      ALU_PASS: alu_d = op_b;
      ALU_FUNC: begin
        unique case (funct3)
          // only R-type uses bit30 to select SUB; for ADDI it is an imm bit
          3'b000:  alu_d = (opcode == OPC_RTYPE && bit30) ? diff_ab : sum_ab;
          3'b001:  alu_d = op_a << shamt;
          3'b010:  alu_d = {31'd0, lt_s_ab};
          3'b011:  alu_d = {31'd0, lt_u_ab};
          3'b100:  alu_d = op_a ^ op_b;
          3'b101:  alu_d = bit30 ? 32'($signed(op_a) >>> shamt) : (op_a >> shamt);
          3'b110:  alu_d = op_a | op_b;
          default: alu_d = op_a & op_b;
        endcase
      end
      default:  alu_d = sum_ab;
    endcase
  end

  // branch comparator on register values, independent of ALUSrc
  logic br_eq, br_lt_s, br_lt_u;
  assign br_eq   = dataA == dataB;
  assign br_lt_s = $signed(dataA) < $signed(dataB);
  assign br_lt_u = dataA < dataB;

  // branch condition decode; 010/011 are not branch encodings
  logic cond;
  always_comb begin
    cond = 1'b0;
    unique case (funct3)
      3'b000:  cond = br_eq;
      3'b001:  cond = !br_eq;
      3'b100:  cond = br_lt_s;
      3'b101:  cond = !br_lt_s;
      3'b110:  cond = br_lt_u;
      3'b111:  cond = !br_lt_u;
      default: cond = 1'b0;
    endcase
  end

  logic taken_d;
  assign taken_d = Branch & cond;

  // target: JALR is register-relative with bit 0 cleared, else PC-relative
  logic [31:0] jalr_sum, pcrel_sum, tgt_d;
  assign jalr_sum  = dataA + imm_ext;
  assign pcrel_sum = PC + imm_ext;
  assign tgt_d     = (opcode == OPC_JALR) ? {jalr_sum[31:1], 1'b0} : pcrel_sum;

  // EX/MEM boundary registers
  logic [31:0] alu_q, wdata_q, tgt_q;
  logic        taken_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_q   <= '0;
      wdata_q <= '0;
      taken_q <= 1'b0;
      tgt_q   <= '0;
    end else begin
      alu_q   <= alu_d;
      wdata_q <= dataB;
      taken_q <= taken_d;
      tgt_q   <= tgt_d;
    end
  end

  assign alu_result     = alu_q;
  assign mem_write_data = wdata_q;
  assign branch_taken   = taken_q;
  assign pc_target      = tgt_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: directed vectors with hand-computed expectations; a driver
// pushes expected results into a scoreboard, a monitor pops and compares.
module tb_ex_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] dataA, dataB, imm_ext, PC, instruction;
  logic [1:0]  ALUOp;
  logic        ALUSrc, Branch;
  logic [31:0] alu_result, mem_write_data, pc_target;
  logic        branch_taken;

  ex_stage dut (
    .clk(clk), .rst_n(rst_n),
    .dataA(dataA), .dataB(dataB), .imm_ext(imm_ext), .PC(PC),
    .instruction(instruction), .ALUOp(ALUOp), .ALUSrc(ALUSrc), .Branch(Branch),
    .alu_result(alu_result), .mem_write_data(mem_write_data),
    .branch_taken(branch_taken), .pc_target(pc_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [31:0] mwd;
    logic        tk;
    logic [31:0] tgt;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic chk(string nm, string fld, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s.%s got %h expected %h", nm, fld, got, exp);
    end
  endtask

  // drive one instruction at negedge and record what must appear after the next edge
  task automatic issue(string nm, logic [31:0] ins, logic [31:0] a, logic [31:0] b,
                       logic [31:0] imm, logic [31:0] pc, logic [1:0] op, logic src,
                       logic br, logic [31:0] er, logic et, logic [31:0] etgt);
    exp_t e;
    @(negedge clk);
    instruction = ins; dataA = a; dataB = b; imm_ext = imm; PC = pc;
    ALUOp = op; ALUSrc = src; Branch = br;
    e.name = nm; e.res = er; e.mwd = b; e.tk = et; e.tgt = etgt;
    sb.push_back(e);
  endtask

  // monitor: one result per clock edge while out of reset
  exp_t m;
  always @(posedge clk) begin
    #1;
    if (rst_n && sb.size() > 0) begin
      m = sb.pop_front();
      chk(m.name, "alu_result", alu_result, m.res);
      chk(m.name, "mem_write_data", mem_write_data, m.mwd);
      chk(m.name, "branch_taken", {31'd0, branch_taken}, {31'd0, m.tk});
      chk(m.name, "pc_target", pc_target, m.tgt);
    end
  end

  task automatic chk_zero(string nm);
    chk(nm, "alu_result", alu_result, 32'd0);
    chk(nm, "mem_write_data", mem_write_data, 32'd0);
    chk(nm, "branch_taken", {31'd0, branch_taken}, 32'd0);
    chk(nm, "pc_target", pc_target, 32'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    instruction = 32'h003100B3; dataA = 32'h1234; dataB = 32'h5678;
    imm_ext = 32'h40; PC = 32'h00400000; ALUOp = 2'b10; ALUSrc = 1'b0; Branch = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk_zero("rst_hold");
    #1 rst_n = 1'b1;

    //    name        instr         A             B             imm           PC            op    src   br    exp_res       tk    exp_tgt
    issue("add",      32'h003100B3, 32'd4,        32'd5,        32'd0,        32'h00400000, 2'b10, 1'b0, 1'b0, 32'h00000009, 1'b0, 32'h00400000);
    issue("addi",     32'h00A10093, 32'd4,        32'd7,        32'd10,       32'h0,        2'b10, 1'b1, 1'b0, 32'h0000000E, 1'b0, 32'h0000000A);
    issue("sub",      32'h403100B3, 32'd4,        32'd5,        32'd0,        32'h0,        2'b10, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 32'h0);
    issue("add_ovf",  32'h003100B3, 32'hFFFFFFFF, 32'd1,        32'd0,        32'h0,        2'b10, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h0);
    issue("addi_b30", 32'h40010093, 32'd4,        32'd0,        32'h400,      32'h0,        2'b10, 1'b1, 1'b0, 32'h00000404, 1'b0, 32'h00000400);
    issue("sra",      32'h4020D0B3, 32'h80000000, 32'd4,        32'd0,        32'h0,        2'b10, 1'b0, 1'b0, 32'hF8000000, 1'b0, 32'h0);
    issue("srai",     32'h4040D093, 32'h80000000, 32'd0,        32'h404,      32'h0,        2'b10, 1'b1, 1'b0, 32'hF8000000, 1'b0, 32'h00000404);
    issue("srl",      32'h0020D0B3, 32'h80000000, 32'd4,        32'd0,        32'h0,        2'b10, 1'b0, 1'b0, 32'h08000000, 1'b0, 32'h0);
    issue("sll",      32'h002090B3, 32'd1,        32'h25,       32'd0,        32'h0,        2'b10, 1'b0, 1'b0, 32'h00000020, 1'b0, 32'h0);
    issue("slt",      32'h0020A0B3, 32'hFFFFFFFF, 32'd1,        32'd0,        32'h0,        2'b10, 1'b0, 1'b0, 32'h00000001, 1'b0, 32'h0);
    issue("sltu",     32'h0020B0B3, 32'hFFFFFFFF, 32'd1,        32'd0,        32'h0,        2'b10, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h0);
    issue("xor",      32'h0020C0B3, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0,        32'h0,        2'b10, 1'b0, 1'b0, 32'hFF00FF00, 1'b0, 32'h0);
    issue("or",       32'h0020E0B3, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0,        32'h0,        2'b10, 1'b0, 1'b0, 32'hFFF0FFF0, 1'b0, 32'h0);
    issue("and",      32'h0020F0B3, 32'hF0F0F0F0, 32'h0FF00FF0, 32'd0,        32'h0,        2'b10, 1'b0, 1'b0, 32'h00F000F0, 1'b0, 32'h0);
    issue("beq_t",    32'h00208263, 32'd10,       32'd10,       32'h64,       32'h00400000, 2'b01, 1'b0, 1'b1, 32'h00000000, 1'b1, 32'h00400064);
    issue("beq_nt",   32'h00208263, 32'd10,       32'd11,       32'h64,       32'h00400000, 2'b01, 1'b0, 1'b1, 32'hFFFFFFFF, 1'b0, 32'h00400064);
    issue("bne_nt",   32'h00209263, 32'd3,        32'd3,        32'h10,       32'h100,      2'b01, 1'b0, 1'b1, 32'h00000000, 1'b0, 32'h00000110);
    issue("blt",      32'h0020C263, 32'hFFFFFFFF, 32'd1,        32'h10,       32'h100,      2'b01, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b1, 32'h00000110);
    issue("bltu",     32'h0020E263, 32'hFFFFFFFF, 32'd1,        32'h10,       32'h100,      2'b01, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 32'h00000110);
    issue("bge",      32'h0020D263, 32'd1,        32'hFFFFFFFF, 32'h10,       32'h100,      2'b01, 1'b0, 1'b1, 32'h00000002, 1'b1, 32'h00000110);
    issue("bgeu",     32'h0020F263, 32'd1,        32'hFFFFFFFF, 32'h10,       32'h100,      2'b01, 1'b0, 1'b1, 32'h00000002, 1'b0, 32'h00000110);
    issue("b_f3_010", 32'h0020A263, 32'd5,        32'd5,        32'h10,       32'h100,      2'b01, 1'b0, 1'b1, 32'h00000000, 1'b0, 32'h00000110);
    issue("beq_src1", 32'h00208263, 32'd10,       32'd10,       32'h64,       32'h100,      2'b01, 1'b1, 1'b1, 32'hFFFFFFA6, 1'b1, 32'h00000164);
    issue("beq_nobr", 32'h00208263, 32'd10,       32'd10,       32'h64,       32'h100,      2'b01, 1'b0, 1'b0, 32'h00000000, 1'b0, 32'h00000164);
    issue("lw",       32'h00812083, 32'h10000004, 32'h55,       32'd8,        32'h0,        2'b00, 1'b1, 1'b0, 32'h1000000C, 1'b0, 32'h00000008);
    issue("jal",      32'h800000EF, 32'd0,        32'd0,        32'h800,      32'h00400000, 2'b00, 1'b1, 1'b0, 32'h00000800, 1'b0, 32'h00400800);
    issue("jalr",     32'h000080E7, 32'h1001,     32'd0,        32'd0,        32'h00400000, 2'b00, 1'b1, 1'b0, 32'h00001001, 1'b0, 32'h00001000);
    issue("jalr_neg", 32'h000080E7, 32'h2000,     32'd0,        32'hFFFFFFFF, 32'h0,        2'b00, 1'b1, 1'b0, 32'h00001FFF, 1'b0, 32'h00001FFE);
    issue("lui",      32'h123450B7, 32'd0,        32'h9,        32'h12345000, 32'h0,        2'b11, 1'b1, 1'b0, 32'h12345000, 1'b0, 32'h12345000);

    // mid-run reset: in-flight instruction is discarded, outputs clear without an edge
    @(negedge clk);
    instruction = 32'h003100B3; dataA = 32'd100; dataB = 32'd200; imm_ext = 32'h8;
    PC = 32'h300; ALUOp = 2'b10; ALUSrc = 1'b0; Branch = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_zero("rst_async");
    @(posedge clk);
    #1 chk_zero("rst_discard");
    #1 rst_n = 1'b1;
    issue("post_rst", 32'h003100B3, 32'd6,        32'd7,        32'h8,        32'h300,      2'b10, 1'b0, 1'b0, 32'h0000000D, 1'b0, 32'h00000308);

    // bounded drain of the scoreboard
    repeat (3) @(posedge clk);
    #2 chk("scoreboard", "pending", sb.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
